// File: rtl/mire_pkg.sv
// Shared definitions for the colour-bar framebuffer writer: RGB565 colours,
// bar colour table and writer state encoding.
package mire_pkg;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam logic [15:0] BAR_COLOURS [8] = '{
    RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
    RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK
  };

  typedef enum logic {
    PAUSE = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Bands past the eighth (HDISP not a multiple of 8) are painted black.
  function automatic logic [15:0] bar_colour(input int unsigned band);
    logic [15:0] colour;
    colour = RGB_BLACK;
    if (band < 8) colour = BAR_COLOURS[band[2:0]];
    return colour;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle between the pattern writer and the SDRAM controller.
interface wshb_if;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [15:0] dat_sm;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (output adr, dat_ms, sel, we, cyc, stb, cti, bte,
                  input  ack, dat_sm);
  modport slave  (input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
                  output ack, dat_sm);
endinterface

// File: rtl/mire_pattern.sv
// Combinational colour-bar generator: pixel column -> RGB565.
// With MIRE_SCROLL_EN the bars are shifted by the frame counter.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int unsigned HDISP = 640,
  parameter int unsigned XW    = 10
) (
  input  logic [XW-1:0] x,
`ifdef MIRE_SCROLL_EN
  input  logic [7:0]    frame_cnt,
`endif
  output logic [15:0]   colour
);

  localparam int unsigned BAND_W = HDISP / 8;

  int unsigned pos;

  always_comb begin
`ifdef MIRE_SCROLL_EN
    pos = (32'(x) + 32'(frame_cnt)) % HDISP;
`else
    pos = 32'(x);
`endif
    colour = bar_colour(pos / BAND_W);
  end

endmodule

// File: rtl/mire_writer.sv
// Endless colour-bar framebuffer writer (Wishbone master, BURST writes per
// tenure, one idle cycle between tenures). Optional scrolling: MIRE_SCROLL_EN.
module mire_writer
  import mire_pkg::*;
#(
  parameter int unsigned HDISP = 640,
  parameter int unsigned VDISP = 480,
  parameter int unsigned BURST = 64
) (
  input logic    CLK,
  input logic    NRST,
  wshb_if.master wshb_ifm
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = $clog2(BURST + 1);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] burst_cnt;
  logic          accept;
  logic          eol;
  logic          eof;
  logic          burst_end;
  logic [15:0]   colour;
  logic          unused_dat_sm;

  assign accept    = (state == WRITE) && wshb_ifm.ack;
  assign eol       = (x == XW'(HDISP - 1));
  assign eof       = eol && (y == YW'(VDISP - 1));
  assign burst_end = (burst_cnt == BW'(BURST - 1));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state     <= PAUSE;
      x         <= '0;
      y         <= '0;
      burst_cnt <= '0;
    end else if (state == PAUSE) begin
      state <= WRITE;
    end else if (accept) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
      // Frame end and burst end on the same ack share one pause.
      if (burst_end || eof) begin
        state     <= PAUSE;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + BW'(1);
      end
    end
  end

`ifdef MIRE_SCROLL_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)              frame_cnt <= '0;
    else if (accept && eof) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

  mire_pattern #(
    .HDISP (HDISP),
    .XW    (XW)
  ) u_pattern (
    .x         (x),
`ifdef MIRE_SCROLL_EN
    .frame_cnt (frame_cnt),
`endif
    .colour    (colour)
  );

  assign wshb_ifm.cyc    = (state == WRITE);
  assign wshb_ifm.stb    = (state == WRITE);
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 2'b11;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;
  assign wshb_ifm.adr    = (32'(HDISP) * 32'(y) + 32'(x)) << 1;
  assign wshb_ifm.dat_ms = colour;

  assign unused_dat_sm = ^wshb_ifm.dat_sm;

endmodule
